waveform_buffer_nslot: RTL

//  Multi-slot waveform store/replay engine; successor to the single-waveform datamover/BRAM streamer.

---
 rtl/waveform_buffer_nslot.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/waveform_buffer_nslot.sv
// Multi-slot AXIS waveform capture/replay engine with repeat count; WFB_REPEAT_TLAST_EN puts tlast on every play.
// Replay latency: request accepted at cycle N, first tvalid at N+2; then 1 beat/clk.
// Backpressure: capture always ready while capturing; replay keeps a 2-entry buffer so RAM prefetch stalls cleanly.
module waveform_buffer_nslot #(
    parameter int DATA_W            = 32,
    parameter int ADDR_W            = 10,
    parameter int NUM_SLOTS         = 4,
    parameter bit WRITE_BEFORE_READ = 1'b1
) (
    input  logic                clk_in1,
    input  logic                aresetn,
    input  logic [127:0]        waveform_parameters,
    input  logic                init_wf_write,
    input  logic                init_wf_read,
    input  logic                wf_abort,
    output logic                wf_write_ready,
    output logic                wf_read_ready,
    output logic                wf_err,
    input  logic [DATA_W-1:0]   wfin_axis_tdata,
    input  logic [DATA_W/8-1:0] wfin_axis_tkeep,
    input  logic                wfin_axis_tvalid,
    input  logic                wfin_axis_tlast,
    output logic                wfin_axis_tready,
    output logic [DATA_W-1:0]   wfout_axis_tdata,
    output logic [DATA_W/8-1:0] wfout_axis_tkeep,
    output logic                wfout_axis_tvalid,
    output logic                wfout_axis_tlast,
    input  logic                wfout_axis_tready
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int SW    = $clog2(NUM_SLOTS);
    localparam int KW    = DATA_W/8;

    typedef enum logic [1:0] {IDLE, WR_DATA, WR_DRAIN, RD_DATA} state_t;
    state_t state;

    logic [31:0]   p_len;
    logic [SW-1:0] p_wr_slot;
    logic [SW-1:0] p_rd_slot;
    logic [15:0]   p_rep;
    assign p_len     = waveform_parameters[31:0];
    assign p_wr_slot = waveform_parameters[32 +: SW];
    assign p_rd_slot = waveform_parameters[40 +: SW];
    assign p_rep     = waveform_parameters[63:48];

    logic unused_ok;
    assign unused_ok = ^{wfin_axis_tkeep, waveform_parameters};

    logic [DATA_W-1:0]    mem [NUM_SLOTS*DEPTH];
    logic [NUM_SLOTS-1:0] slot_valid;
    logic [ADDR_W:0]      slot_len [NUM_SLOTS];

    logic [SW-1:0] wr_slot;
    logic [ADDR_W:0] wr_addr;
    logic [ADDR_W:0] wr_len;
    logic [ADDR_W:0] wr_next;
    logic            wr_hs;

    assign wfin_axis_tready = (state == WR_DATA) || (state == WR_DRAIN);
    assign wr_hs            = (state == WR_DATA) && wfin_axis_tvalid;
    assign wr_next          = wr_addr + 1'b1;

    assign wf_read_ready = wf_write_ready & (slot_valid[p_rd_slot] | !WRITE_BEFORE_READ);
    assign wfout_axis_tkeep = {KW{wfout_axis_tvalid}};

    logic [SW-1:0]     rd_slot, cur_slot;
    logic [ADDR_W-1:0] rd_addr, cur_addr;
    logic [ADDR_W:0]   rd_len, cur_len;
    logic [15:0]       rd_rep, cur_rep, rd_rep_tot, cur_rep_tot;
    logic              rd_done;
    logic              start_wr, start_rd, abort_now;
    logic              play_end, final_beat, beat_last;
    logic              issue, pop, finish, out_free, room;
    logic [1:0]        occ;
    logic              ram_vld, ram_last, sk_vld, sk_last, abrt;
    logic [DATA_W-1:0] ram_q, sk_dat;

    assign start_wr  = (state == IDLE) && init_wf_write && wf_write_ready;
    assign start_rd  = (state == IDLE) && !start_wr && init_wf_read && wf_read_ready;
    assign abort_now = (state == RD_DATA) && wf_abort;

    // The first RAM read is issued in the accepting cycle, straight from the request fields.
    always_comb begin
        if (state == IDLE) begin
            cur_slot    = p_rd_slot;
            cur_addr    = '0;
            cur_len     = slot_len[p_rd_slot];
            cur_rep     = '0;
            cur_rep_tot = p_rep;
        end else begin
            cur_slot    = rd_slot;
            cur_addr    = rd_addr;
            cur_len     = rd_len;
            cur_rep     = rd_rep;
            cur_rep_tot = rd_rep_tot;
        end
    end

    assign play_end   = (cur_addr == ADDR_W'(cur_len - 1'b1));
    assign final_beat = play_end && (cur_rep == cur_rep_tot);
`ifdef WFB_REPEAT_TLAST_EN
    assign beat_last  = play_end;
`else
    assign beat_last  = final_beat;
`endif

    assign pop      = wfout_axis_tvalid && wfout_axis_tready;
    assign finish   = pop && wfout_axis_tlast;
    assign out_free = !wfout_axis_tvalid || pop;
    // Entries that will sit in output+skid next cycle; a new read only goes out if it will have a home.
    assign occ      = 2'(wfout_axis_tvalid) + 2'(sk_vld) + 2'(ram_vld) - 2'(pop);
    assign room     = occ < 2'd2;
    assign issue    = start_rd || ((state == RD_DATA) && !rd_done && room && !finish);

    always_ff @(posedge clk_in1) begin
        if (aresetn && wr_hs) begin
            mem[{wr_slot, wr_addr[ADDR_W-1:0]}] <= wfin_axis_tdata;
        end
        if (issue) begin
            ram_q <= mem[{cur_slot, cur_addr}];
        end
    end

    always_ff @(posedge clk_in1) begin
        if (!aresetn) begin
            state             <= IDLE;
            wf_write_ready    <= 1'b0;
            wf_err            <= 1'b0;
            slot_valid        <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_len[i] <= (ADDR_W+1)'(DEPTH);
            end
            wr_slot           <= '0;
            wr_addr           <= '0;
            wr_len            <= '0;
            rd_slot           <= '0;
            rd_addr           <= '0;
            rd_len            <= '0;
            rd_rep            <= '0;
            rd_rep_tot        <= '0;
            rd_done           <= 1'b0;
            ram_vld           <= 1'b0;
            ram_last          <= 1'b0;
            sk_vld            <= 1'b0;
            sk_last           <= 1'b0;
            sk_dat            <= '0;
            abrt              <= 1'b0;
            wfout_axis_tvalid <= 1'b0;
            wfout_axis_tlast  <= 1'b0;
            wfout_axis_tdata  <= '0;
        end else begin
            wf_write_ready <= 1'b0;
            wf_err         <= 1'b0;
            ram_vld        <= issue;

            if (issue) begin
                ram_last   <= beat_last;
                rd_slot    <= cur_slot;
                rd_len     <= cur_len;
                rd_rep_tot <= cur_rep_tot;
                rd_done    <= final_beat;
                rd_addr    <= play_end ? '0 : cur_addr + 1'b1;
                rd_rep     <= (play_end && !final_beat) ? cur_rep + 16'd1 : cur_rep;
            end

            if (abort_now) begin
                abrt <= 1'b1;
            end

            // Output register refills from skid first, then from the RAM; RAM data lands in skid when stalled.
            if (out_free) begin
                if (sk_vld) begin
                    wfout_axis_tvalid <= 1'b1;
                    wfout_axis_tdata  <= sk_dat;
                    wfout_axis_tlast  <= sk_last | abrt | abort_now;
                    sk_vld            <= ram_vld;
                    sk_dat            <= ram_q;
                    sk_last           <= ram_last;
                end else begin
                    wfout_axis_tvalid <= ram_vld;
                    wfout_axis_tdata  <= ram_q;
                    wfout_axis_tlast  <= ram_vld & (ram_last | abrt | abort_now);
                end
            end else begin
                if (ram_vld) begin
                    sk_vld  <= 1'b1;
                    sk_dat  <= ram_q;
                    sk_last <= ram_last;
                end
                if (abort_now) begin
                    wfout_axis_tlast <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (start_wr) begin
                        if (p_len == 32'd0) begin
                            wf_err         <= 1'b1;
                            wf_write_ready <= 1'b1;
                        end else begin
                            state   <= WR_DATA;
                            wr_slot <= p_wr_slot;
                            wr_addr <= '0;
                            wr_len  <= (p_len > 32'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : p_len[ADDR_W:0];
                        end
                    end else if (start_rd) begin
                        state <= RD_DATA;
                    end else begin
                        wf_write_ready <= 1'b1;
                        if (init_wf_read && wf_write_ready && !wf_read_ready) begin
                            wf_err <= 1'b1;
                        end
                    end
                end
                WR_DATA: begin
                    if (wr_hs) begin
                        wr_addr <= wr_next;
                        if (wfin_axis_tlast || (wr_next == wr_len)) begin
                            slot_valid[wr_slot] <= 1'b1;
                            slot_len[wr_slot]   <= wr_next;
                            if (wfin_axis_tlast) begin
                                state <= IDLE;
                            end else begin
                                wf_err <= 1'b1;
                                state  <= WR_DRAIN;
                            end
                        end
                    end
                end
                WR_DRAIN: begin
                    if (wfin_axis_tvalid && wfin_axis_tlast) begin
                        state <= IDLE;
                    end
                end
                RD_DATA: begin
                    if (finish) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Leaving replay discards any prefetched words still in flight.
            if (finish) begin
                wfout_axis_tvalid <= 1'b0;
                wfout_axis_tlast  <= 1'b0;
                sk_vld            <= 1'b0;
                ram_vld           <= 1'b0;
                abrt              <= 1'b0;
            end
        end
    end
endmodule
